c8b_32b: RTL and testbench
==========================

# c8b_32b

Byte-to-word deserializer for the PCIe PHY receive path; inverse of the 32b→8b transmit serializer. Accepts one byte per clock with a valid qualifier, assembles four consecutive valid bytes into a 32-bit word (first byte received = bits [7:0]), and presents the word with a one-cycle valid pulse. Partial words interrupted by a valid gap are discarded and flagged.

## Interface
- Parameters: none; byte order and word width are fixed.
- clock  input  1  byte clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- data_in  input  8  received byte
- valid_in  input  1  data_in is valid this cycle
- data_out  output  32  last completed word; holds its value between words
- valid_out  output  1  one-cycle pulse: data_out carries a newly completed word
- err_out  output  1  one-cycle pulse: a partial word was discarded

## Operation
- Internal state:
  - byte index idx (2 bits, 0..3)
  - 24-bit holding register for bytes 0..2
- State machine:
  - IDLE: idx==0.
  - COLLECT: idx in 1..3.
- Rising edge with valid_in=1:
  - idx<3: store data_in in holding byte idx, then idx<=idx+1.
  - idx==3: data_out<={data_in, hold[23:16], hold[15:8], hold[7:0]}, valid_out<=1, idx<=0 (wrap to IDLE).
- Rising edge with valid_in=0:
  - idx!=0: partial word discarded, err_out<=1, idx<=0, data_out unchanged.
  - idx==0: no state change.
- valid_out and err_out are 0 on every edge not named above. They are never both 1 in the same cycle.
- data_out changes only on word completion or reset.
- Back-to-back words need no idle cycle. Byte 0 of the next word may be sampled on the edge after byte 3.
- data_in is ignored whenever valid_in=0.
- Word alignment: the first valid byte after reset, after any discard, or after a completed word is byte 0.

## Timing
- Reset asserted (asynchronous, effective immediately, independent of clock):
  - data_out=32'h0, valid_out=0, err_out=0, idx=0, holding register=0.
- Reset mid-word: the partial word is lost silently, with no err_out pulse.
- First valid edge after reset deassertion samples byte 0.
- Latency: valid_out and data_out update on the same edge that samples byte 3. They are visible in the cycle after that edge. Byte 0 to valid_out is 4 edges.
- Throughput: one 32-bit word per 4 clocks at full valid_in rate.
- err_out asserts on the edge that samples valid_in=0 with idx!=0, for exactly one cycle.
- A second gap cycle while idx==0 produces no further err_out.
- Valid byte on the edge right after a discard: accepted as byte 0 (err_out=1 and new collection start coincide on that edge).

## Test plan
- Reset then 4 valid bytes 8'hA1,8'hB2,8'hC3,8'hD4 on consecutive edges -> after the 4th edge, data_out=32'hD4C3B2A1, valid_out=1 for one cycle, err_out=0.
- Continuous valid for 8 bytes 01..08 -> valid_out pulses after edge 4 (32'h04030201) and edge 8 (32'h08070605), 0 elsewhere.
- Bytes 11,22 valid, one cycle valid_in=0, then 33,44,55,66 valid -> err_out=1 for one cycle after the gap edge; data_out=32'h66554433 with valid_out; 11/22 never appear.
- Idle gap with idx==0 between two full words -> no err_out; data_out holds the first word through the gap.
- Assert reset asynchronously after bytes 77,88 -> outputs 0 immediately, no err_out. After release, bytes 01,02,03,04 -> data_out=32'h04030201.
- Random valid_in pattern of 1000 cycles against a reference model -> every valid_out word and err_out pulse matches the model exactly.

Source files
------------

// File: rtl/c8b_32b.sv
// ---------------------------------------------------------------------------
// c8b_32b : byte-to-word deserializer for the PCIe PHY receive path.
//
// Collects four consecutive valid bytes into one 32-bit word. The first byte
// of a word lands in bits [7:0]. A completed word is presented with a
// one-cycle valid pulse. A gap in valid_in part-way through a word throws
// the partial bytes away and raises a one-cycle error pulse.
//
// Ports
//   clock     in   1  byte clock, rising edge active
//   reset     in   1  asynchronous, active-high reset
//   data_in   in   8  received byte
//   valid_in  in   1  data_in is valid this cycle
//   data_out  out 32  last completed word, held between words
//   valid_out out  1  one-cycle pulse, data_out carries a new word
//   err_out   out  1  one-cycle pulse, a partial word was discarded
// ---------------------------------------------------------------------------
module c8b_32b (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        err_out
);

    // IDLE means idx==0 (the next valid byte starts a new word).
    // COLLECT means idx is 1..3 (part of a word is held).
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  idx_r;
    logic [1:0]  idx_nxt_s;
    logic [23:0] hold_r;
    logic [23:0] hold_nxt_s;
    logic [31:0] data_out_r;
    logic [31:0] data_nxt_s;
    logic        valid_out_r;
    logic        valid_nxt_s;
    logic        err_out_r;
    logic        err_nxt_s;

    // State register. Every output is registered, so each pulse lasts exactly
    // one cycle after the edge that produced it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= 2'd0;
            hold_r      <= 24'h0;
            data_out_r  <= 32'h0;
            valid_out_r <= 1'b0;
            err_out_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            hold_r      <= hold_nxt_s;
            data_out_r  <= data_nxt_s;
            valid_out_r <= valid_nxt_s;
            err_out_r   <= err_nxt_s;
        end
    end

    // Next-state and output decode. Both pulses default low, and data_out
    // keeps its value unless a word completes.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        hold_nxt_s  = hold_r;
        data_nxt_s  = data_out_r;
        valid_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (valid_in) begin
                    // First byte of a new word
                    hold_nxt_s[7:0] = data_in;
                    idx_nxt_s       = 2'd1;
                    state_nxt_s     = COLLECT;
                end else begin
                    // A gap with nothing collected is not an error
                    idx_nxt_s   = 2'd0;
                    state_nxt_s = IDLE;
                end
            end

            COLLECT: begin
                if (!valid_in) begin
                    // Gap mid-word: drop the partial bytes and realign
                    err_nxt_s   = 1'b1;
                    idx_nxt_s   = 2'd0;
                    state_nxt_s = IDLE;
                end else if (idx_r == 2'd3) begin
                    // Fourth byte completes the word. The byte goes straight
                    // to the output and is never held.
                    data_nxt_s  = {data_in, hold_r};
                    valid_nxt_s = 1'b1;
                    idx_nxt_s   = 2'd0;
                    state_nxt_s = IDLE;
                end else begin
                    case (idx_r)
                        2'd1:    hold_nxt_s[15:8]  = data_in;
                        2'd2:    hold_nxt_s[23:16] = data_in;
                        default: hold_nxt_s[7:0]   = data_in;
                    endcase
                    idx_nxt_s   = idx_r + 2'd1;
                    state_nxt_s = COLLECT;
                end
            end

            default: begin
                // Unreachable encoding: go back to word alignment
                idx_nxt_s   = 2'd0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_out_r;
    assign err_out   = err_out_r;

endmodule

// File: tb/tb_c8b_32b.sv
// ---------------------------------------------------------------------------
// tb_c8b_32b : self-checking bench for c8b_32b.
// The stimulus process drives bytes and runs a queue-based reference model.
// Every expected output event goes into a scoreboard queue. A separate
// monitor compares the DUT outputs against that queue on each falling edge.
// ---------------------------------------------------------------------------
module tb_c8b_32b;

    logic        clock;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        err_out;

    c8b_32b dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .err_out   (err_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          is_err;
        logic [31:0] word;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  bytes_q[$];
    logic [31:0] exp_data;
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: act on the values sampled at the edge that just passed
    task automatic model_edge(input logic v, input logic [7:0] d);
        ev_t e;
        if (reset) begin
            bytes_q.delete();
            exp_data = 32'h0;
        end else if (v) begin
            bytes_q.push_back(d);
            if (bytes_q.size() == 4) begin
                exp_data = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};
                e.is_err = 1'b0;
                e.word   = exp_data;
                exp_q.push_back(e);
                bytes_q.delete();
            end
        end else if (bytes_q.size() != 0) begin
            e.is_err = 1'b1;
            e.word   = exp_data;
            exp_q.push_back(e);
            bytes_q.delete();
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clock);
        model_edge(v, d);
        #2;
    endtask

    // Monitor: compare every output event against the scoreboard
    always @(negedge clock) begin
        ev_t e;
        checks++;
        if (valid_out && err_out) begin
            errors++;
            $display("FAIL both_pulses: valid_out=%b err_out=%b, expected never both 1", valid_out, err_out);
        end
        if (valid_out || err_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: valid_out=%b err_out=%b, expected no event", valid_out, err_out);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (e.is_err !== err_out || (!e.is_err) !== valid_out) begin
                    errors++;
                    $display("FAIL event_kind: valid_out=%b err_out=%b, expected err=%b", valid_out, err_out, e.is_err);
                end else if (!e.is_err && data_out !== e.word) begin
                    errors++;
                    $display("FAIL event_word: got %h, expected %h", data_out, e.word);
                end
            end
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_event: %0d expected events not presented", exp_q.size());
            exp_q.delete();
        end
        if (data_out !== exp_data) begin
            errors++;
            $display("FAIL data_hold: got %h, expected %h", data_out, exp_data);
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        exp_data = 32'h0;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        #12;
        check("reset_data", data_out, 32'h0);
        check("reset_valid", {31'h0, valid_out}, 32'h0);
        check("reset_err", {31'h0, err_out}, 32'h0);
        reset = 1'b0;

        // Basic word
        step(1'b1, 8'hA1); step(1'b1, 8'hB2); step(1'b1, 8'hC3);
        check("pre_word_valid", {31'h0, valid_out}, 32'h0);
        step(1'b1, 8'hD4);
        check("word1_data", data_out, 32'hD4C3B2A1);
        check("word1_valid", {31'h0, valid_out}, 32'h1);
        check("word1_err", {31'h0, err_out}, 32'h0);
        step(1'b0, 8'hFF);
        check("word1_pulse_end", {31'h0, valid_out}, 32'h0);

        // Back-to-back words
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i));
            if (i == 4) check("b2b_w1", data_out, 32'h04030201);
            if (i == 4 || i == 8) check("b2b_valid", {31'h0, valid_out}, 32'h1);
            else check("b2b_novalid", {31'h0, valid_out}, 32'h0);
        end
        check("b2b_w2", data_out, 32'h08070605);

        // Discard after two bytes
        step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b0, 8'h99);
        check("gap_err", {31'h0, err_out}, 32'h1);
        check("gap_data_held", data_out, 32'h08070605);
        step(1'b1, 8'h33);
        check("gap_err_end", {31'h0, err_out}, 32'h0);
        step(1'b1, 8'h44); step(1'b1, 8'h55); step(1'b1, 8'h66);
        check("gap_word", data_out, 32'h66554433);

        // Idle gap at idx 0 is silent
        step(1'b0, 8'h00);
        check("idle_noerr1", {31'h0, err_out}, 32'h0);
        step(1'b0, 8'h00);
        check("idle_noerr2", {31'h0, err_out}, 32'h0);
        check("idle_hold", data_out, 32'h66554433);

        // Asynchronous reset mid-word
        step(1'b1, 8'h77); step(1'b1, 8'h88);
        reset = 1'b1;
        #1;
        exp_data = 32'h0;
        bytes_q.delete();
        check("arst_data", data_out, 32'h0);
        check("arst_err", {31'h0, err_out}, 32'h0);
        step(1'b0, 8'h00);
        reset = 1'b0;
        check("arst_err_after", {31'h0, err_out}, 32'h0);
        step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03); step(1'b1, 8'h04);
        check("arst_word", data_out, 32'h04030201);

        // Randomized traffic against the model
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom));
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
